// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - GF(2^255-19) constants, field-element type and inverter FSM states
package fe_pkg;

   localparam int W        = 255;
   localparam int EXP_BITS = 255;

   typedef logic [W-1:0] fe_t;

   localparam fe_t P_MOD   = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
   localparam fe_t EXP_INV = P_MOD - fe_t'(2);

   // Top exponent bit is absorbed by loading acc with x, so scanning starts one below it.
   localparam logic [7:0] IDX_START = 8'(EXP_BITS - 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQ_ISSUE,
      ST_SQ_WAIT,
      ST_MU_ISSUE,
      ST_MU_WAIT,
      ST_FINISH
   } inv_state_e;

endpackage

// File: rtl/fe_invert_seq_if.sv
// rtl/fe_invert_seq_if.sv - request and multiplier handshake bundle; zero_err exists with FE_INV_ZERO_DETECT_EN
interface fe_invert_seq_if;
   import fe_pkg::*;

   logic start;
   fe_t  x_in;
   logic busy;
   logic done;
   fe_t  y_out;
`ifdef FE_INV_ZERO_DETECT_EN
   logic zero_err;
`endif
   logic mul_start;
   fe_t  mul_a;
   fe_t  mul_b;
   fe_t  mul_result;
   logic mul_valid;

   modport master (
      output start, x_in, mul_result, mul_valid,
`ifdef FE_INV_ZERO_DETECT_EN
      input  zero_err,
`endif
      input  busy, done, y_out, mul_start, mul_a, mul_b
   );

   modport slave (
      input  start, x_in, mul_result, mul_valid,
`ifdef FE_INV_ZERO_DETECT_EN
      output zero_err,
`endif
      output busy, done, y_out, mul_start, mul_a, mul_b
   );

endinterface

// File: rtl/fe_exp_bitsel.sv
// rtl/fe_exp_bitsel.sv - combinational lookup of inversion exponent bit idx
module fe_exp_bitsel
   import fe_pkg::*;
(
   input  logic [7:0] idx,
   output logic       e_bit
);

   assign e_bit = EXP_INV[idx];

endmodule

// File: rtl/fe_invert_seq.sv
// rtl/fe_invert_seq.sv - x^(p-2) mod p by left-to-right square-and-multiply; FE_INV_ZERO_DETECT_EN short-circuits x=0
module fe_invert_seq
   import fe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   fe_invert_seq_if.slave   bus
);

   inv_state_e state, state_nxt;
   fe_t        acc, x_reg, y_reg, mul_a_reg, mul_b_reg;
   logic [7:0] idx;
   logic       busy_reg, done_reg, mul_start_reg;
   logic       e_bit;
   logic       accept;

   fe_exp_bitsel u_bitsel (
      .idx   (idx),
      .e_bit (e_bit)
   );

   // done is registered, so a start coinciding with it is refused here.
   assign accept = (state == ST_IDLE) && bus.start && !done_reg;

`ifdef FE_INV_ZERO_DETECT_EN
   logic x_zero;
   logic zero_err_reg;
   assign x_zero       = (bus.x_in == '0);
   assign bus.zero_err = zero_err_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
`ifdef FE_INV_ZERO_DETECT_EN
               state_nxt = x_zero ? ST_FINISH : ST_SQ_ISSUE;
`else
               state_nxt = ST_SQ_ISSUE;
`endif
            end
         end
         ST_SQ_ISSUE: state_nxt = ST_SQ_WAIT;
         ST_SQ_WAIT: begin
            if (bus.mul_valid) begin
               if (e_bit)           state_nxt = ST_MU_ISSUE;
               else if (idx == '0)  state_nxt = ST_FINISH;
               else                 state_nxt = ST_SQ_ISSUE;
            end
         end
         ST_MU_ISSUE: state_nxt = ST_MU_WAIT;
         ST_MU_WAIT: begin
            if (bus.mul_valid) state_nxt = (idx == '0) ? ST_FINISH : ST_SQ_ISSUE;
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc           <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
         mul_a_reg     <= '0;
         mul_b_reg     <= '0;
         idx           <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         mul_start_reg <= 1'b0;
`ifdef FE_INV_ZERO_DETECT_EN
         zero_err_reg  <= 1'b0;
`endif
      end else begin
         mul_start_reg <= 1'b0;
         done_reg      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  x_reg    <= bus.x_in;
                  acc      <= bus.x_in;
                  idx      <= IDX_START;
                  busy_reg <= 1'b1;
`ifdef FE_INV_ZERO_DETECT_EN
                  zero_err_reg <= 1'b0;
`endif
               end
            end
            ST_SQ_ISSUE: begin
               mul_start_reg <= 1'b1;
               mul_a_reg     <= acc;
               mul_b_reg     <= acc;
            end
            ST_SQ_WAIT: begin
               if (bus.mul_valid) begin
                  acc <= bus.mul_result;
                  // idx stays put when a multiply follows; it steps after that multiply.
                  if (!e_bit && idx != '0) idx <= idx - 8'd1;
               end
            end
            ST_MU_ISSUE: begin
               mul_start_reg <= 1'b1;
               mul_a_reg     <= acc;
               mul_b_reg     <= x_reg;
            end
            ST_MU_WAIT: begin
               if (bus.mul_valid) begin
                  acc <= bus.mul_result;
                  if (idx != '0) idx <= idx - 8'd1;
               end
            end
            ST_FINISH: begin
               y_reg    <= acc;
               done_reg <= 1'b1;
               busy_reg <= 1'b0;
`ifdef FE_INV_ZERO_DETECT_EN
               zero_err_reg <= (x_reg == '0);
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.y_out     = y_reg;
   assign bus.mul_start = mul_start_reg;
   assign bus.mul_a     = mul_a_reg;
   assign bus.mul_b     = mul_b_reg;

endmodule

// File: tb/tb_fe_invert_seq.sv
// tb/tb_fe_invert_seq.sv - randomized check of fe_invert_seq against modular-arithmetic reference and latency-configurable multiplier
module tb_fe_invert_seq;

   typedef logic [254:0] fe_t;
   localparam logic [509:0] P_TB = (510'd1 << 255) - 510'd19;
   localparam int BUDGET = 506 * 22 + 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fe_invert_seq_if bus ();

   fe_invert_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   int  lat_fix = 3;
   bit  lat_rand = 1'b0;
   int  lat_hi = 20;
   bit  spur_en = 1'b0;
   int  mul_cnt = 0;
   bit  overlap_err = 1'b0;

   task automatic chk(input string tag, input fe_t got, input fe_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic fe_t mulmod(input fe_t a, input fe_t b);
      logic [509:0] t;
      t = 510'(a) * 510'(b);
      return fe_t'(t % P_TB);
   endfunction

   // Right-to-left exponentiation: independent of the DUT's scan order.
   function automatic fe_t powmod(input fe_t x, input logic [509:0] e);
      fe_t r, base;
      r = fe_t'(1);
      base = x;
      for (int i = 0; i < 255; i++) begin
         if (e[i]) r = mulmod(r, base);
         base = mulmod(base, base);
      end
      return r;
   endfunction

   function automatic fe_t rand_fe();
      fe_t v;
      for (int i = 0; i < 8; i++) v[i*32 +: 31] = 31'($urandom);
      for (int i = 0; i < 8; i++) v[i*32+31 +: 1] = 1'($urandom);
      v[254] = 1'b0;
      if (v == '0) v = fe_t'(7);
      return v;
   endfunction

   // Multiplier model, evaluated on the falling edge.
   initial begin
      bit   pending;
      int   cnt;
      fe_t  prod;
      pending = 1'b0;
      cnt = 0;
      prod = '0;
      bus.mul_valid = 1'b0;
      bus.mul_result = '0;
      forever begin
         @(negedge clk);
         bus.mul_valid = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else begin
            if (pending) begin
               cnt--;
               if (cnt == 0) begin
                  bus.mul_valid = 1'b1;
                  bus.mul_result = prod;
                  pending = 1'b0;
               end
            end else if (spur_en && !bus.mul_start && $urandom_range(3) == 0) begin
               bus.mul_valid = 1'b1;
               bus.mul_result = rand_fe();
            end
            if (bus.mul_start) begin
               if (pending) overlap_err = 1'b1;
               pending = 1'b1;
               cnt = lat_rand ? int'($urandom_range(lat_hi, 1)) : lat_fix;
               prod = mulmod(bus.mul_a, bus.mul_b);
               mul_cnt++;
            end
         end
      end
   end

   task automatic run_inv(input fe_t x, input int dup_at, input int abort_ops,
                          output fe_t y, output int n, output bit got_done, output bit zerr);
      @(negedge clk);
      bus.x_in = x;
      bus.start = 1'b1;
      mul_cnt = 0;
      n = 0;
      got_done = 1'b0;
      zerr = 1'b0;
      y = '0;
      while (n < BUDGET) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            bus.start = 1'b0;
            chk("busy_after_start", fe_t'(bus.busy), fe_t'(1));
         end
         if (dup_at > 0 && n == dup_at) begin
            bus.start = 1'b1;
            bus.x_in = rand_fe();
         end
         if (dup_at > 0 && n == dup_at + 1) bus.start = 1'b0;
         if (abort_ops > 0 && mul_cnt >= abort_ops) begin
            rst_n = 1'b0;
            break;
         end
         if (bus.done) begin
            got_done = 1'b1;
            y = bus.y_out;
`ifdef FE_INV_ZERO_DETECT_EN
            zerr = bus.zero_err;
`endif
            break;
         end
      end
      if (abort_ops == 0 && !got_done) chk("done_timeout", fe_t'(0), fe_t'(1));
   endtask

   initial begin
      fe_t y, x, inv2;
      int  n;
      bit  gd, ze;
      bit  seen;

      bus.start = 1'b0;
      bus.x_in = '0;
      inv2 = fe_t'((P_TB + 510'd1) >> 1);

      repeat (3) @(negedge clk);
      chk("rst_busy", fe_t'(bus.busy), '0);
      chk("rst_done", fe_t'(bus.done), '0);
      chk("rst_y", bus.y_out, '0);
      chk("rst_mul_start", fe_t'(bus.mul_start), '0);
      chk("rst_mul_a", bus.mul_a, '0);
      chk("rst_mul_b", bus.mul_b, '0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // x=1, fixed latency 3
      lat_fix = 3; lat_rand = 1'b0;
      run_inv(fe_t'(1), 0, 0, y, n, gd, ze);
      chk("x1_y", y, fe_t'(1));
      chk("x1_latency", fe_t'(n), fe_t'(506 * 5 + 2));
      chk("x1_ops", fe_t'(mul_cnt), fe_t'(506));
      chk("x1_busy_at_done", fe_t'(bus.busy), '0);

      // start coincident with done must be refused
      bus.x_in = fe_t'(5);
      bus.start = 1'b1;
      mul_cnt = 0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_on_done_busy", fe_t'(bus.busy), '0);
      repeat (4) @(negedge clk);
      chk("start_on_done_ops", fe_t'(mul_cnt), '0);
      chk("y_holds", bus.y_out, fe_t'(1));

      // x=2
      lat_fix = 2;
      run_inv(fe_t'(2), 0, 0, y, n, gd, ze);
      chk("x2_y", y, inv2);
      chk("x2_y_times_2", mulmod(y, fe_t'(2)), fe_t'(1));
      chk("x2_latency", fe_t'(n), fe_t'(506 * 4 + 2));

      // x=p-1 with random per-op latency
      lat_rand = 1'b1; lat_hi = 20;
      run_inv(fe_t'(P_TB - 510'd1), 0, 0, y, n, gd, ze);
      chk("pm1_y", y, fe_t'(P_TB - 510'd1));
      chk("pm1_ops", fe_t'(mul_cnt), fe_t'(506));
      lat_rand = 1'b0;

      // x=0
      lat_fix = 1;
      run_inv('0, 0, 0, y, n, gd, ze);
      chk("x0_y", y, '0);
`ifdef FE_INV_ZERO_DETECT_EN
      chk("x0_zero_err", fe_t'(ze), fe_t'(1));
      chk("x0_latency", fe_t'(n), fe_t'(2));
      chk("x0_ops", fe_t'(mul_cnt), '0);
      repeat (2) @(negedge clk);
      run_inv(fe_t'(3), 0, 0, y, n, gd, ze);
      chk("zero_err_cleared", fe_t'(ze), '0);
      chk("x3_y", mulmod(y, fe_t'(3)), fe_t'(1));
`else
      chk("x0_ops", fe_t'(mul_cnt), fe_t'(506));
      chk("x0_latency", fe_t'(n), fe_t'(506 * 3 + 2));
`endif

      // second start at cycle 100 ignored; spurious mul_valid outside wait states
      repeat (2) @(negedge clk);
      lat_rand = 1'b1; lat_hi = 6; spur_en = 1'b1;
      x = rand_fe();
      run_inv(x, 100, 0, y, n, gd, ze);
      chk("dup_y", y, powmod(x, P_TB - 510'd2));
      chk("dup_check_inv", mulmod(x, y), fe_t'(1));
      chk("dup_ops", fe_t'(mul_cnt), fe_t'(506));
      spur_en = 1'b0;

      // abort by reset after 200 multiplies
      repeat (2) @(negedge clk);
      run_inv(rand_fe(), 0, 200, y, n, gd, ze);
      @(negedge clk);
      chk("abort_busy", fe_t'(bus.busy), '0);
      chk("abort_y", bus.y_out, '0);
      chk("abort_mul_a", bus.mul_a, '0);
      chk("abort_mul_b", bus.mul_b, '0);
      chk("abort_mul_start", fe_t'(bus.mul_start), '0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("abort_no_done", fe_t'(seen), '0);
      run_inv(fe_t'(2), 0, 0, y, n, gd, ze);
      chk("post_abort_x2_y", y, inv2);

      // random operands
      for (int k = 0; k < 3; k++) begin
         repeat (2) @(negedge clk);
         x = rand_fe();
         run_inv(x, 0, 0, y, n, gd, ze);
         chk("rand_y", y, powmod(x, P_TB - 510'd2));
         chk("rand_inv", mulmod(x, y), fe_t'(1));
      end

      chk("single_outstanding", fe_t'(overlap_err), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fe_invert_seq.md
Name: fe_invert_seq

Overview:
- Field-element inverter for GF(p), p = 2^255 - 19.
- Computes y = x^(p-2) mod p (Fermat) by left-to-right square-and-multiply.
- Sits directly upstream of the sequential 255-bit modular multiplier. It drives the multiplier's operands and start, and consumes its result/valid.
- Used by the scalar-multiplication back end for the final affine conversion (Z^-1).

Parameters:
- W, 255, field element width.
- EXP_BITS, 255, exponent length; the top bit is implicit 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_in  in  W  operand; captured on an accepted start; must be < p.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; y_out is valid on and after this cycle.
- y_out  out  W  x^-1 mod p; holds until the next accepted start.
- mul_start  out  1  one-cycle pulse to the multiplier.
- mul_a  out  W  multiplier operand a; held stable while waiting.
- mul_b  out  W  multiplier operand b; held stable while waiting.
- mul_result  in  W  multiplier product a*b mod p.
- mul_valid  in  1  one-cycle pulse; mul_result is valid in that cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, mul_start=0; y_out, mul_a, mul_b, acc, x_reg = 0; bit index = 0.
- Exponent is the constant E = p-2 = 2^255-21: all ones except bits 2 and 4.
- FSM states and transitions:
  - IDLE: on start, x_reg<=x_in, acc<=x_in (covers E[254]=1), idx<=253 -> SQ_ISSUE.
  - SQ_ISSUE: mul_a=mul_b=acc, mul_start=1 for exactly one cycle -> SQ_WAIT.
  - SQ_WAIT: on mul_valid, acc<=mul_result. If E[idx]=1 -> MU_ISSUE. Else if idx==0 -> FINISH. Else idx--, -> SQ_ISSUE.
  - MU_ISSUE: mul_a=acc, mul_b=x_reg, mul_start pulse -> MU_WAIT.
  - MU_WAIT: on mul_valid, acc<=mul_result. If idx==0 -> FINISH. Else idx--, -> SQ_ISSUE.
  - FINISH: y_out<=acc, done=1 for one cycle, busy=0 -> IDLE.
- Operation counts: 254 squarings + 252 multiplies = 506 mul_start pulses per inversion.
- Latency = 506*(L_mul+2) + 2 cycles, where L_mul = cycles from mul_start to mul_valid. Any multiplier latency >= 1 must be tolerated.
- mul_valid outside SQ_WAIT/MU_WAIT is ignored. Never more than one outstanding multiply.
- start while busy is ignored; no queueing.
- start in the same cycle as done is not accepted. start is accepted one cycle later in IDLE.
- x_in = 0 yields y_out = 0 via the full sequence; no special casing unless the optional feature is enabled.
- Reset mid-operation aborts immediately, with no done. The multiplier is reset by the same rst_n at system level.
- idx is 8 bits; it never wraps, because idx==0 is checked before decrement.

Optional Feature:
- Macro: FE_INV_ZERO_DETECT_EN.
- With the macro:
  - Adds output port zero_err (1 bit, reset 0).
  - On an accepted start with x_in==0, go directly to FINISH: y_out=0, zero_err=1 with done, no mul_start issued.
  - zero_err is cleared on the next accepted start.
- Without the macro: no zero_err port; zero input runs the full 506-operation sequence.

Decomposition:
- Shared package fe_pkg holds:
  - W.
  - P_MOD (2^255-19).
  - EXP_INV (p-2).
  - Field-element typedef.
  - FSM state enum for this block.
- One natural sub-module: fe_exp_bitsel, a combinational exponent bit lookup by idx. A single-module implementation is acceptable.
- The multiplier is instantiated at the parent level, not inside this block.

Test Plan:
- Use a multiplier model with configurable latency for all scenarios.
- x_in=1, L_mul=3 -> y_out=1; done after exactly 506*5+2 cycles; exactly 506 mul_start pulses counted.
- x_in=2 -> y_out = 0x3FFF...FFF7 (2^254-9); check y_out*2 mod p == 1.
- x_in = p-1 = 0x7FFF...FFEC -> y_out = 0x7FFF...FFEC. Repeat with random L_mul in 1..20 per operation; same result.
- x_in=0:
  - Macro off -> y_out=0, 506 ops.
  - Macro on -> y_out=0, zero_err=1, done 2 cycles after start, 0 mul_start.
- start pulsed again at cycle 100 of a run -> ignored; result equals the first operand's inverse. Spurious mul_valid in SQ_ISSUE -> ignored.
- rst_n deasserted at op 200 -> busy=0, done never pulses, outputs zeroed. A subsequent start with x_in=2 completes correctly.
